player_move_ctrl: RTL and testbench

Per-frame motion controller for the player sprite. Owns the player's top-left screen position, vertical velocity and jump/fall state. Updates them once per video frame from keyboard inputs and from edge-collision codes produced by the player bitmap. Its topLeftX/topLeftY feed the player's square/offset logic, which drives the player bitmap; the bitmap's HitEdgeCode, gated by the collision detector, comes back into this block.

---
 rtl/player_move_ctrl.sv | 168 ++++++++++++++++
 tb/tb_player_move_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// Player sprite motion controller: per-frame position, vertical velocity and
// jump/fall state, driven by key levels and accumulated edge-collision codes.
module player_move_ctrl #(
    parameter int INITIAL_X  = 280,
    parameter int INITIAL_Y  = 447,
    parameter int X_SPEED    = 2,
    parameter int JUMP_SPEED = -12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 8,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 607,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 447
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        jumpKey,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  playerState
);

    typedef enum logic [1:0] {
        GROUNDED = 2'b00,
        JUMPING  = 2'b01,
        FALLING  = 2'b10
    } state_t;

    localparam logic signed [11:0] INIT_X12 = 12'(INITIAL_X);
    localparam logic signed [11:0] INIT_Y12 = 12'(INITIAL_Y);
    localparam logic signed [11:0] XSPD12   = 12'(X_SPEED);
    localparam logic signed [11:0] JSPD12   = 12'(JUMP_SPEED);
    localparam logic signed [11:0] XMIN12   = 12'(X_MIN);
    localparam logic signed [11:0] XMAX12   = 12'(X_MAX);
    localparam logic signed [11:0] YMIN12   = 12'(Y_MIN);
    localparam logic signed [11:0] YMAX12   = 12'(Y_MAX);
    localparam logic signed [5:0]  JSPD6    = 6'(JUMP_SPEED);
    localparam logic signed [5:0]  GRAV6    = 6'(GRAVITY);
    localparam logic signed [5:0]  MAXF6    = 6'(MAX_FALL);

    logic signed [11:0] x_q, x_d, y_q, y_d;
    logic signed [5:0]  vy_q, vy_d;
    state_t             st_q, st_d;
    logic [3:0]         hit_acc_q, hit_acc_d;
    logic               jump_pend_q, jump_pend_d;
    logic               jump_key_prev_q;

    logic               jump_edge;
    logic signed [11:0] dx;
    logic signed [11:0] y_nxt;
    logic signed [5:0]  vy_inc;

    function automatic logic signed [11:0] sext_vy(input logic signed [5:0] v);
        return $signed({{6{v[5]}}, v});
    endfunction

    function automatic logic signed [11:0] clamp_x(input logic signed [11:0] v);
        if (v < XMIN12)
            return XMIN12;
        else if (v > XMAX12)
            return XMAX12;
        else
            return v;
    endfunction

    assign jump_edge = jumpKey & ~jump_key_prev_q;
    assign vy_inc    = vy_q + GRAV6;

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        vy_d        = vy_q;
        st_d        = st_q;
        y_nxt       = y_q;
        dx          = '0;
        hit_acc_d   = hit_acc_q | (collision ? HitEdgeCode : 4'b0000);
        jump_pend_d = jump_pend_q | jump_edge;

        if (startOfFrame) begin
            // Inputs coinciding with the strobe belong to the next frame.
            hit_acc_d   = collision ? HitEdgeCode : 4'b0000;
            jump_pend_d = jump_edge;

            if (rightKey && !leftKey && !hit_acc_q[1])
                dx = XSPD12;
            else if (leftKey && !rightKey && !hit_acc_q[3])
                dx = -XSPD12;
            x_d = clamp_x(x_q + dx);

            case (st_q)
                GROUNDED: begin
                    if (jump_pend_q) begin
                        y_nxt = y_q + JSPD12;
                        vy_d  = JSPD6 + GRAV6;
                        st_d  = JUMPING;
                    end else if (!hit_acc_q[0] && y_q != YMAX12) begin
                        vy_d = '0;
                        st_d = FALLING;
                    end
                end
                JUMPING: begin
                    if (hit_acc_q[2]) begin
                        vy_d = '0;
                        st_d = FALLING;
                    end else begin
                        y_nxt = y_q + sext_vy(vy_q);
                        vy_d  = vy_inc;
                        if (!vy_inc[5])
                            st_d = FALLING;
                    end
                end
                FALLING: begin
                    if (hit_acc_q[0]) begin
                        vy_d = '0;
                        st_d = GROUNDED;
                    end else begin
                        y_nxt = y_q + sext_vy(vy_q);
                        vy_d  = (vy_inc > MAXF6) ? MAXF6 : vy_inc;
                    end
                end
                default: st_d = FALLING;
            endcase

            // Floor and ceiling override whatever the state logic decided.
            if (y_nxt >= YMAX12) begin
                y_d  = YMAX12;
                vy_d = '0;
                st_d = GROUNDED;
            end else if (y_nxt < YMIN12) begin
                y_d  = YMIN12;
                vy_d = '0;
                st_d = FALLING;
            end else begin
                y_d = y_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            x_q             <= INIT_X12;
            y_q             <= INIT_Y12;
            vy_q            <= '0;
            st_q            <= FALLING;
            hit_acc_q       <= '0;
            jump_pend_q     <= 1'b0;
            jump_key_prev_q <= 1'b0;
        end else begin
            x_q             <= x_d;
            y_q             <= y_d;
            vy_q            <= vy_d;
            st_q            <= st_d;
            hit_acc_q       <= hit_acc_d;
            jump_pend_q     <= jump_pend_d;
            jump_key_prev_q <= jumpKey;
        end
    end

    assign topLeftX    = x_q[10:0];
    assign topLeftY    = y_q[10:0];
    assign playerState = st_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed scenarios plus random traffic, all
// checked against an integer model of the movement rules.
module tb_player_move_ctrl;

    localparam int ST_G = 0, ST_J = 1, ST_F = 2;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        leftKey, rightKey, jumpKey;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic [10:0] topLeftX, topLeftY;
    logic [1:0]  playerState;

    int checks   = 0;
    int failures = 0;

    int         m_x, m_y, m_vy, m_st;
    logic [3:0] m_acc;
    bit         m_jp, m_jk;

    player_move_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .leftKey      (leftKey),
        .rightKey     (rightKey),
        .jumpKey      (jumpKey),
        .collision    (collision),
        .HitEdgeCode  (HitEdgeCode),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .playerState  (playerState)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one call per rising edge, using the levels present then.
    task automatic model_step();
        int  dx, nx, ny, nvy, nst;
        bit  edge_seen;
        logic [3:0] h;
        if (!resetN) begin
            m_x = 280; m_y = 447; m_vy = 0; m_st = ST_F;
            m_acc = 4'b0; m_jp = 0; m_jk = 0;
            return;
        end
        edge_seen = jumpKey && !m_jk;
        m_jk = jumpKey;
        if (!startOfFrame) begin
            if (collision) m_acc = m_acc | HitEdgeCode;
            if (edge_seen) m_jp = 1;
            return;
        end
        h = m_acc;
        dx = 0;
        if (rightKey && !leftKey) dx = 2;
        if (leftKey && !rightKey) dx = -2;
        if (dx > 0 && h[1]) dx = 0;
        if (dx < 0 && h[3]) dx = 0;
        nx = m_x + dx;
        if (nx < 0) nx = 0;
        if (nx > 607) nx = 607;
        ny = m_y; nvy = m_vy; nst = m_st;
        if (m_st == ST_G) begin
            if (m_jp) begin
                ny = m_y - 12; nvy = -11; nst = ST_J;
            end else if (!h[0] && m_y != 447) begin
                nvy = 0; nst = ST_F;
            end
        end else if (m_st == ST_J) begin
            if (h[2]) begin
                nvy = 0; nst = ST_F;
            end else begin
                ny = m_y + m_vy; nvy = m_vy + 1;
                if (nvy >= 0) nst = ST_F;
            end
        end else begin
            if (h[0]) begin
                nvy = 0; nst = ST_G;
            end else begin
                ny = m_y + m_vy;
                nvy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
            end
        end
        if (ny >= 447) begin
            ny = 447; nvy = 0; nst = ST_G;
        end else if (ny < 0) begin
            ny = 0; nvy = 0; nst = ST_F;
        end
        m_x = nx; m_y = ny; m_vy = nvy; m_st = nst;
        m_acc = collision ? HitEdgeCode : 4'b0;
        m_jp  = edge_seen;
    endtask

    task automatic cycle(input logic sof, input logic col, input logic [3:0] code);
        startOfFrame = sof;
        collision    = col;
        HitEdgeCode  = code;
        @(posedge clk);
        model_step();
        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'b0;
    endtask

    task automatic frame();
        cycle(1'b1, 1'b0, 4'b0);
        cycle(1'b0, 1'b0, 4'b0);
    endtask

    task automatic press_jump();
        jumpKey = 1'b1;
        cycle(1'b0, 1'b0, 4'b0);
        jumpKey = 1'b0;
        cycle(1'b0, 1'b0, 4'b0);
    endtask

    task automatic fall_to_ground();
        for (int i = 0; i < 60; i++) begin
            if (m_st == ST_G && m_y == 447) break;
            frame();
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        cycle(1'b0, 1'b0, 4'b0);
        cycle(1'b0, 1'b0, 4'b0);
        checks++;
        if (topLeftX !== 11'd280 || topLeftY !== 11'd447 || playerState !== 2'b10) begin
            failures++;
            $display("FAIL reset: got x=%0d y=%0d st=%b, want x=280 y=447 st=10",
                     topLeftX, topLeftY, playerState);
        end
        resetN = 1'b1;
        cycle(1'b0, 1'b0, 4'b0);
    endtask

    task automatic test_first_frame();
        frame();
        checks++;
        if (topLeftX !== 11'd280 || topLeftY !== 11'd447 || playerState !== 2'b00) begin
            failures++;
            $display("FAIL first_frame: got x=%0d y=%0d st=%b, want x=280 y=447 st=00",
                     topLeftX, topLeftY, playerState);
        end
    endtask

    task automatic test_walk_right();
        rightKey = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            frame();
            checks++;
            if (topLeftX !== 11'(280 + 2 * k) || topLeftY !== 11'd447) begin
                failures++;
                $display("FAIL walk_right[%0d]: got x=%0d y=%0d, want x=%0d y=447",
                         k, topLeftX, topLeftY, 280 + 2 * k);
            end
        end
        rightKey = 1'b0;
    endtask

    task automatic test_jump_arc();
        int want_y;
        press_jump();
        for (int k = 1; k <= 12; k++) begin
            frame();
            want_y = 447 - (12 * k - (k * (k - 1)) / 2);
            checks++;
            if (topLeftY !== 11'(want_y) || playerState !== ((k <= 11) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL jump_arc[%0d]: got y=%0d st=%b, want y=%0d st=%b",
                         k, topLeftY, playerState, want_y, (k <= 11) ? 2'b01 : 2'b10);
            end
        end
        for (int k = 0; k < 40 && !(m_st == ST_G); k++) begin
            frame();
            checks++;
            if (topLeftY !== 11'(m_y) || playerState !== 2'(m_st)) begin
                failures++;
                $display("FAIL jump_fall[%0d]: got y=%0d st=%b, want y=%0d st=%0d",
                         k, topLeftY, playerState, m_y, m_st);
            end
        end
        checks++;
        if (topLeftY !== 11'd447 || playerState !== 2'b00) begin
            failures++;
            $display("FAIL jump_land: got y=%0d st=%b, want y=447 st=00", topLeftY, playerState);
        end
    endtask

    task automatic test_feet_hit();
        press_jump();
        for (int k = 0; k < 14; k++) frame();
        cycle(1'b0, 1'b1, 4'b0001);
        frame();
        checks++;
        if (topLeftY !== 11'd370 || playerState !== 2'b00) begin
            failures++;
            $display("FAIL feet_hit: got y=%0d st=%b, want y=370 st=00", topLeftY, playerState);
        end
        frame();
        checks++;
        if (topLeftY !== 11'd370 || playerState !== 2'b10) begin
            failures++;
            $display("FAIL ledge_walkoff: got y=%0d st=%b, want y=370 st=10", topLeftY, playerState);
        end
        fall_to_ground();
        checks++;
        if (topLeftY !== 11'd447 || playerState !== 2'b00) begin
            failures++;
            $display("FAIL feet_hit_land: got y=%0d st=%b, want y=447 st=00", topLeftY, playerState);
        end
    endtask

    task automatic test_edge_block();
        int xb;
        xb = m_x;
        rightKey = 1'b1;
        cycle(1'b0, 1'b1, 4'b0010);
        frame();
        checks++;
        if (topLeftX !== 11'(xb)) begin
            failures++;
            $display("FAIL right_block: got x=%0d, want x=%0d", topLeftX, xb);
        end
        cycle(1'b1, 1'b1, 4'b0010);
        checks++;
        if (topLeftX !== 11'(xb + 2)) begin
            failures++;
            $display("FAIL hit_at_sof_now: got x=%0d, want x=%0d", topLeftX, xb + 2);
        end
        frame();
        checks++;
        if (topLeftX !== 11'(xb + 2)) begin
            failures++;
            $display("FAIL hit_at_sof_next: got x=%0d, want x=%0d", topLeftX, xb + 2);
        end
        rightKey = 1'b0;
        leftKey  = 1'b1;
        cycle(1'b0, 1'b1, 4'b1000);
        frame();
        checks++;
        if (topLeftX !== 11'(xb + 2)) begin
            failures++;
            $display("FAIL left_block: got x=%0d, want x=%0d", topLeftX, xb + 2);
        end
        rightKey = 1'b1;
        frame();
        checks++;
        if (topLeftX !== 11'(xb + 2)) begin
            failures++;
            $display("FAIL both_keys: got x=%0d, want x=%0d", topLeftX, xb + 2);
        end
        leftKey  = 1'b0;
        rightKey = 1'b0;
    endtask

    task automatic test_x_clamp();
        int n;
        rightKey = 1'b1;
        n = 0;
        while (m_x != 607 && n < 400) begin frame(); n++; end
        frame();
        checks++;
        if (topLeftX !== 11'd607) begin
            failures++;
            $display("FAIL x_max_clamp: got x=%0d, want x=607", topLeftX);
        end
        rightKey = 1'b0;
        leftKey  = 1'b1;
        n = 0;
        while (m_x != 1 && n < 400) begin frame(); n++; end
        checks++;
        if (topLeftX !== 11'd1) begin
            failures++;
            $display("FAIL x_reach_1: got x=%0d, want x=1", topLeftX);
        end
        for (int k = 0; k < 2; k++) begin
            frame();
            checks++;
            if (topLeftX !== 11'd0) begin
                failures++;
                $display("FAIL x_min_clamp[%0d]: got x=%0d, want x=0", k, topLeftX);
            end
        end
        leftKey = 1'b0;
    endtask

    task automatic test_jump_at_sof();
        jumpKey = 1'b1;
        cycle(1'b1, 1'b0, 4'b0);
        checks++;
        if (topLeftY !== 11'd447 || playerState !== 2'b00) begin
            failures++;
            $display("FAIL jump_at_sof_now: got y=%0d st=%b, want y=447 st=00", topLeftY, playerState);
        end
        cycle(1'b0, 1'b0, 4'b0);
        frame();
        checks++;
        if (topLeftY !== 11'd435 || playerState !== 2'b01) begin
            failures++;
            $display("FAIL jump_at_sof_next: got y=%0d st=%b, want y=435 st=01", topLeftY, playerState);
        end
        fall_to_ground();
        frame();
        checks++;
        if (topLeftY !== 11'd447 || playerState !== 2'b00) begin
            failures++;
            $display("FAIL held_no_rejump: got y=%0d st=%b, want y=447 st=00", topLeftY, playerState);
        end
        jumpKey = 1'b0;
        cycle(1'b0, 1'b0, 4'b0);
    endtask

    task automatic test_reset_midjump();
        press_jump();
        for (int k = 0; k < 4; k++) frame();
        jumpKey = 1'b1;
        resetN  = 1'b0;
        cycle(1'b0, 1'b0, 4'b0);
        checks++;
        if (topLeftX !== 11'd280 || topLeftY !== 11'd447 || playerState !== 2'b10) begin
            failures++;
            $display("FAIL reset_midjump: got x=%0d y=%0d st=%b, want x=280 y=447 st=10",
                     topLeftX, topLeftY, playerState);
        end
        resetN = 1'b1;
        cycle(1'b0, 1'b0, 4'b0);
        frame();
        frame();
        checks++;
        if (topLeftY !== 11'd447 || playerState !== 2'b00) begin
            failures++;
            $display("FAIL reset_held_jump: got y=%0d st=%b, want y=447 st=00", topLeftY, playerState);
        end
        jumpKey = 1'b0;
        cycle(1'b0, 1'b0, 4'b0);
        press_jump();
        frame();
        checks++;
        if (topLeftY !== 11'd435 || playerState !== 2'b01) begin
            failures++;
            $display("FAIL repress_jump: got y=%0d st=%b, want y=435 st=01", topLeftY, playerState);
        end
        fall_to_ground();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) leftKey  = ~leftKey;
            if ($urandom_range(0, 15) == 0) rightKey = ~rightKey;
            if ($urandom_range(0, 7)  == 0) jumpKey  = ~jumpKey;
            resetN = ($urandom_range(0, 799) != 0);
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)));
            checks++;
            if (topLeftX !== 11'(m_x) || topLeftY !== 11'(m_y) || playerState !== 2'(m_st)) begin
                failures++;
                $display("FAIL random[%0d]: got x=%0d y=%0d st=%b, want x=%0d y=%0d st=%0d",
                         i, topLeftX, topLeftY, playerState, m_x, m_y, m_st);
            end
        end
        resetN = 1'b1;
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        leftKey      = 1'b0;
        rightKey     = 1'b0;
        jumpKey      = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'b0;
        @(negedge clk);
        test_reset();
        test_first_frame();
        test_walk_right();
        test_jump_arc();
        test_feet_hit();
        test_edge_block();
        test_jump_at_sof();
        test_x_clamp();
        test_reset_midjump();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
